alu_pipe: RTL

Parametrised, handshaked successor to the core's combinational ALU.
- Widens the operation set to add, sub, and, or, xor, slt, sltu, sll, srl, sra and iterative mul (low half).
- Registers the result and Zero/Negative/Carry/Overflow flags.
- Uses valid/ready on both sides, so the datapath can stall on a multi-cycle multiply.
- Sits between operand fetch and writeback in the multi-cycle core build.

---
 rtl/alu_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags and an iterative
// shift-add multiplier; single-cycle ops retire in one cycle, mul in WIDTH.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             is_mul_op;
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             lt_s;
    logic             lt_u;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    cnt;
    logic             mul_last;

    assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul_op = MUL_EN && (ALUControl == OP_MUL);

    // Subtraction reuses the adder: invert B and inject the carry-in.
    always_comb begin
        is_sub = (ALUControl == OP_SUB);
        b_op   = is_sub ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        lt_s   = $signed(A) < $signed(B);
        lt_u   = A < B;
        shamt  = B[SW-1:0];
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        unique case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) &&
                          (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            OP_MUL:  alu_ill = !MUL_EN;
            default: alu_ill = 1'b1;
        endcase
    end

    assign acc_step = acc + (b_sh[0] ? a_sh : '0);
    assign mul_last = (state == MUL) && (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && is_mul_op)
                    state_nxt = MUL;
                else if (out_valid && !out_ready)
                    state_nxt = HOLD;
            end
            MUL: begin
                if (mul_last)
                    state_nxt = IDLE;
            end
            HOLD: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A fresh result overrides the drain of the previous one on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
        end else if (accept && !is_mul_op) begin
            out_valid <= 1'b1;
            Result    <= alu_res;
            Zero      <= (alu_res == '0);
            Negative  <= alu_res[WIDTH-1];
            Carry     <= alu_c;
            Overflow  <= alu_v;
            Illegal   <= alu_ill;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            Result    <= acc_step;
            Zero      <= (acc_step == '0);
            Negative  <= acc_step[WIDTH-1];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (accept && is_mul_op) begin
            a_sh <= A;
            b_sh <= B;
            acc  <= '0;
            cnt  <= CW'(WIDTH);
        end else if (state == MUL) begin
            acc  <= acc_step;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule
